// File: rtl/rom_boot_loader.sv
// Boot loader: parses a framed byte stream (sync, 16-bit word length, LE payload) into RAM writes.
// Optional trailing XOR checksum byte enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_boot_loader #(
    parameter int unsigned MEM_ADDR_WIDTH = 13,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    output logic                      rx_ready_o,
    input  logic                      clear_i,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_data_o,
    output logic [3:0]                mem_size_o,
    output logic                      cpu_hold_o,
    output logic                      done_o,
    output logic                      error_o
);

`ifdef ROM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StLen0, StLen1, StData, StWrite, StChk, StDone, StError
    } state_e;
    localparam state_e StFinal = StChk;
`else
    typedef enum logic [2:0] {
        StIdle, StLen0, StLen1, StData, StWrite, StDone, StError
    } state_e;
    localparam state_e StFinal = StDone;
`endif

    // Largest legal length is exactly the RAM capacity in words.
    localparam logic [32:0] MaxWords = 33'(1) << MEM_ADDR_WIDTH;

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               data_q, data_d;
    logic [15:0]               count_q, count_d;
    logic [15:0]               len_q, len_d;
    logic [1:0]                idx_q, idx_d;
    logic [15:0]               len_full;
    logic                      accept;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]                csum_q, csum_d;
`endif

    always_comb begin
        rx_ready_o = 1'b0;
        cpu_hold_o = 1'b0;
        unique case (state_q)
            StIdle:                    rx_ready_o = 1'b1;
            StLen0, StLen1, StData:    begin rx_ready_o = 1'b1; cpu_hold_o = 1'b1; end
`ifdef ROM_LOADER_CHECKSUM_EN
            StChk:                     begin rx_ready_o = 1'b1; cpu_hold_o = 1'b1; end
`endif
            StWrite:                   cpu_hold_o = 1'b1;
            default:                   ;
        endcase
    end

    assign accept     = rx_valid_i && rx_ready_o;
    assign len_full   = {rx_data_i, len_q[7:0]};
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign mem_size_o = (state_q == StWrite) ? 4'b1111 : 4'b0000;
    assign done_o     = (state_q == StDone);
    assign error_o    = (state_q == StError);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        len_d   = len_q;
        idx_d   = idx_q;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept && rx_data_i == SYNC_BYTE) state_d = StLen0;
            end
            StLen0: begin
                if (accept) begin
                    len_d[7:0] = rx_data_i;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    len_d[15:8] = rx_data_i;
                    addr_d      = '0;
                    idx_d       = 2'd0;
                    count_d     = 16'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_d      = 8'd0;
`endif
                    if (33'(len_full) > MaxWords) state_d = StError;
                    else if (len_full == 16'd0)   state_d = StFinal;
                    else                          state_d = StData;
                end
            end
            StData: begin
                if (accept) begin
                    data_d[8*idx_q +: 8] = rx_data_i;
                    idx_d                = idx_q + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_d               = csum_q ^ rx_data_i;
`endif
                    if (idx_q == 2'd3) state_d = StWrite;
                end
            end
            StWrite: begin
                addr_d  = addr_q + MEM_ADDR_WIDTH'(1);
                count_d = count_q + 16'd1;
                state_d = (count_q + 16'd1 == len_q) ? StFinal : StData;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) state_d = (rx_data_i == csum_q) ? StDone : StError;
            end
`endif
            StDone, StError: begin
                if (clear_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule
